// File: rtl/if_prefetch.sv
// Pipelined instruction prefetch: up to MAX_OUTSTANDING cache reads in flight, FIFO_DEPTH-entry queue.
// Optional IF_PREFETCH_BYPASS_EN lets a kept response skip an empty, unheld queue.
module if_prefetch #(
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int unsigned CACHE_AW        = 25,
    parameter int unsigned PC_AW           = 23,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [2:0]  HOLD_PC_LVL     = 3'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                jump_flag_i,
    input  logic [31:0]         jump_addr_i,
    input  logic [2:0]          hold_flag_i,
    input  logic                jtag_reset_flag_i,
    output logic [31:0]         inst_addr_o,
    output logic [31:0]         inst_o,
    output logic                inst_valid,
    output logic [CACHE_AW-1:0] o_p_addr,
    output logic [3:0]          o_p_byte_en,
    output logic [31:0]         o_p_writedata,
    output logic                o_p_read,
    output logic                o_p_write,
    input  logic [31:0]         i_p_readdata,
    input  logic                i_p_readdata_valid,
    input  logic                i_p_waitrequest
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_fifo_cnt;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_mem_addr [FIFO_DEPTH];
    logic [31:0]   r_mem_data [FIFO_DEPTH];
    logic [31:0]   r_inst_addr;
    logic [31:0]   r_inst;
    logic          r_inst_valid;

    logic          w_flush;
    logic [31:0]   w_flush_pc;
    logic          w_hold;
    logic [CW-1:0] w_credit;
    logic          w_accept;
    logic          w_ret;
    logic          w_keep;
    logic          w_pop;
    logic          w_push;
    logic          w_bypass;
    logic [CW-1:0] w_acc_c;
    logic [CW-1:0] w_ret_c;
    logic [CW-1:0] w_push_c;
    logic [CW-1:0] w_pop_c;

    assign w_flush    = jump_flag_i | jtag_reset_flag_i;
    assign w_flush_pc = jtag_reset_flag_i ? RESET_PC : jump_addr_i;
    assign w_hold     = (hold_flag_i >= HOLD_PC_LVL);

    // Words already queued plus words that will still be kept must fit in the queue.
    assign w_credit = r_fifo_cnt + r_out_cnt - r_drop_cnt;
    assign o_p_read = ~w_flush & (r_out_cnt < MAX_C) & (w_credit < DEPTH_C);
    assign w_accept = o_p_read & ~i_p_waitrequest;
    assign w_ret    = i_p_readdata_valid;
    assign w_keep   = w_ret & (r_drop_cnt == '0) & ~w_flush;
    assign w_pop    = ~w_flush & ~w_hold & (r_fifo_cnt != '0);

`ifdef IF_PREFETCH_BYPASS_EN
    assign w_bypass = w_keep & ~w_hold & (r_fifo_cnt == '0);
`else
    assign w_bypass = 1'b0;
`endif
    assign w_push = w_keep & ~w_bypass;

    assign w_acc_c  = {{(CW-1){1'b0}}, w_accept};
    assign w_ret_c  = {{(CW-1){1'b0}}, w_ret};
    assign w_push_c = {{(CW-1){1'b0}}, w_push};
    assign w_pop_c  = {{(CW-1){1'b0}}, w_pop};

    assign o_p_addr      = CACHE_AW'(r_fetch_pc[PC_AW-1:0]);
    assign o_p_byte_en   = 4'h0;
    assign o_p_writedata = 32'h0;
    assign o_p_write     = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_fifo_cnt <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_out_cnt <= r_out_cnt + w_acc_c - w_ret_c;
            if (w_flush) begin
                // Every read still in flight after this edge is stale.
                r_fetch_pc <= w_flush_pc;
                r_resp_pc  <= w_flush_pc;
                r_drop_cnt <= r_out_cnt - w_ret_c;
                r_fifo_cnt <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd1;
                if (w_keep) r_resp_pc <= r_resp_pc + 32'd1;
                if (w_ret && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop) r_rptr <= r_rptr + 1'b1;
                r_fifo_cnt <= r_fifo_cnt + w_push_c - w_pop_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= r_resp_pc;
            r_mem_data[r_wptr] <= i_p_readdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_addr  <= 32'h0;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
        end else if (w_flush) begin
            r_inst_addr  <= 32'h0;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
        end else if (!w_hold) begin
            if (r_fifo_cnt != '0) begin
                r_inst_addr  <= r_mem_addr[r_rptr];
                r_inst       <= r_mem_data[r_rptr];
                r_inst_valid <= 1'b1;
            end else if (w_bypass) begin
                r_inst_addr  <= r_resp_pc;
                r_inst       <= i_p_readdata;
                r_inst_valid <= 1'b1;
            end else begin
                r_inst_addr  <= 32'h0;
                r_inst       <= 32'h0;
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign inst_addr_o = r_inst_addr;
    assign inst_o      = r_inst;
    assign inst_valid  = r_inst_valid;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with an in-order cache model of configurable return latency.
// Expected response-to-valid timing follows IF_PREFETCH_BYPASS_EN when defined.
module tb_if_prefetch;

`ifdef IF_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 1 : 2;
    localparam int MAX_OUT = 2;
    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [2:0] HOLD_LVL = 3'd1;

    logic        clk;
    logic        rst_n;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_flag_i;
    logic        jtag_reset_flag_i;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;
    logic        inst_valid;
    logic [24:0] o_p_addr;
    logic [3:0]  o_p_byte_en;
    logic [31:0] o_p_writedata;
    logic        o_p_read;
    logic        o_p_write;
    logic [31:0] i_p_readdata;
    logic        i_p_readdata_valid;
    logic        i_p_waitrequest;

    if_prefetch #(
        .RESET_PC(RST_PC),
        .CACHE_AW(25),
        .PC_AW(23),
        .FIFO_DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAX_OUT),
        .HOLD_PC_LVL(HOLD_LVL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .jump_flag_i(jump_flag_i),
        .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i),
        .jtag_reset_flag_i(jtag_reset_flag_i),
        .inst_addr_o(inst_addr_o),
        .inst_o(inst_o),
        .inst_valid(inst_valid),
        .o_p_addr(o_p_addr),
        .o_p_byte_en(o_p_byte_en),
        .o_p_writedata(o_p_writedata),
        .o_p_read(o_p_read),
        .o_p_write(o_p_write),
        .i_p_readdata(i_p_readdata),
        .i_p_readdata_valid(i_p_readdata_valid),
        .i_p_waitrequest(i_p_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_acc = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_out;
    logic [31:0] q_addr [$];
    int          q_due [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample requests, advance the edge, score outputs, drive next response.
    task automatic tick();
        logic acc;
        logic hld;
        logic fl;
        logic [31:0] tgt;
        #1;
        hld = (hold_flag_i >= HOLD_LVL);
        fl  = jump_flag_i | jtag_reset_flag_i;
        tgt = jtag_reset_flag_i ? RST_PC : jump_addr_i;
        if (fl) chk("read_during_flush", {31'b0, o_p_read}, 32'd0);
        if (o_p_read) chk("fetch_addr", {7'b0, o_p_addr}, model_pc);
        acc = o_p_read & ~i_p_waitrequest;
        if (acc) begin
            q_addr.push_back({7'b0, o_p_addr});
            q_due.push_back(cyc + lat);
            n_acc++;
        end
        if (i_p_readdata_valid) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) model_pc = model_pc + 32'd1;
        if (fl) begin
            model_pc = tgt;
            exp_out  = tgt;
            chk("flush_clears_valid", {31'b0, inst_valid}, 32'd0);
        end else if (!hld && inst_valid === 1'b1) begin
            chk("stream_addr", inst_addr_o, exp_out);
            chk("stream_data", inst_o, ~exp_out);
            exp_out = exp_out + 32'd1;
        end
        chk("outstanding_limit", {31'b0, (q_addr.size() <= MAX_OUT)}, 32'd1);
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            i_p_readdata_valid = 1'b1;
            i_p_readdata       = ~q_addr[0];
        end else begin
            i_p_readdata_valid = 1'b0;
            i_p_readdata       = 32'h0;
        end
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int n;
        n = 0;
        while (inst_valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, inst_valid}, 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        logic [31:0] f_addr;
        int acc0;
        int n;

        rst_n = 1'b0;
        jump_flag_i = 1'b0;
        jump_addr_i = 32'h0;
        hold_flag_i = 3'd0;
        jtag_reset_flag_i = 1'b0;
        i_p_readdata = 32'h0;
        i_p_readdata_valid = 1'b0;
        i_p_waitrequest = 1'b0;
        model_pc = RST_PC;
        exp_out = RST_PC;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, inst_valid}, 32'd0);
        chk("reset_inst", inst_o, 32'h0);
        chk("reset_addr", inst_addr_o, 32'h0);
        chk("tied_ctrl", {27'b0, o_p_write, o_p_byte_en}, 32'h0);
        chk("tied_wdata", o_p_writedata, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("first_read", {31'b0, o_p_read}, 32'd1);
        chk("first_addr", {7'b0, o_p_addr}, RST_PC);

        // Streaming from reset with a zero-wait, one-cycle-return cache
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= LAT) begin
                chk("fill_valid", {31'b0, inst_valid}, 32'd1);
                chk("fill_addr", inst_addr_o, 32'(i - LAT));
            end else begin
                chk("fill_bubble", {31'b0, inst_valid}, 32'd0);
            end
        end

        // Hold: output frozen, prefetch continues until the queue credit is used up
        held = 32'(5 - LAT);
        acc0 = n_acc;
        hold_flag_i = 3'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", {31'b0, inst_valid}, 32'd1);
            chk("hold_addr", inst_addr_o, held);
        end
        chk("hold_accepts", 32'(n_acc - acc0), held + 32'd1 + 32'(DEPTH) - 32'd6);
        chk("hold_no_read", {31'b0, o_p_read}, 32'd0);
        chk("hold_fetch_pc", {7'b0, o_p_addr}, held + 32'd1 + 32'(DEPTH));
        hold_flag_i = 3'd0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("release_valid", {31'b0, inst_valid}, 32'd1);
            chk("release_addr", inst_addr_o, held + 32'(j));
        end

        // Jump to 0x40 with two reads outstanding (hold asserted too; jump wins)
        lat = 3;
        n = 0;
        while (q_addr.size() != 2 && n < 10) begin
            tick();
            n++;
        end
        chk("two_outstanding", q_addr.size(), 32'd2);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h40;
        hold_flag_i = 3'd2;
        tick();
        chk("jump_fetch_pc", {7'b0, o_p_addr}, 32'h40);
        jump_flag_i = 1'b0;
        hold_flag_i = 3'd0;
        lat = 1;
        wait_valid(20, "jump_wait_valid");
        chk("jump_target_addr", inst_addr_o, 32'h40);
        chk("jump_target_data", inst_o, ~32'h40);
        tick();
        wait_valid(10, "jump_next_valid");
        chk("jump_next_addr", inst_addr_o, 32'h41);

        // Wait-request stall
        repeat (3) tick();
        f_addr = model_pc;
        i_p_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_addr_frozen", {7'b0, o_p_addr}, f_addr);
        end
        chk("stall_drained", {31'b0, inst_valid}, 32'd0);
        i_p_waitrequest = 1'b0;
        wait_valid(10, "stall_wait_valid");
        chk("stall_resume_addr", inst_addr_o, f_addr);

        // JTAG reset with one read outstanding
        repeat (3) tick();
        chk("jtag_one_outstanding", q_addr.size(), 32'd1);
        jtag_reset_flag_i = 1'b1;
        tick();
        chk("jtag_fetch_pc", {7'b0, o_p_addr}, RST_PC);
        jtag_reset_flag_i = 1'b0;
        wait_valid(10, "jtag_wait_valid");
        chk("jtag_target_addr", inst_addr_o, RST_PC);
        chk("jtag_target_data", inst_o, ~RST_PC);

        // Single isolated response: bypass timing
        i_p_waitrequest = 1'b1;
        repeat (6) tick();
        chk("iso_idle_valid", {31'b0, inst_valid}, 32'd0);
        chk("iso_idle_outstanding", q_addr.size(), 32'd0);
        i_p_waitrequest = 1'b0;
        tick();
        chk("iso_req_edge", {31'b0, inst_valid}, 32'd0);
        i_p_waitrequest = 1'b1;
        tick();
        chk("iso_resp_edge", {31'b0, inst_valid}, {31'b0, BYP});
        tick();
        chk("iso_resp_edge_plus1", {31'b0, inst_valid}, {31'b0, ~BYP});
        i_p_waitrequest = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
